main_pn: RTL and testbench



---
 rtl/main_pn.sv | 163 ++++++++++++++++
 tb/tb_main_pn.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_pn.sv
// main_pn: single-cycle 8-bit CPU top with PC, 256x16 ROM, 4x8 register file, ALU and 256x8 RAM.
// One instruction retires per clk edge. There is no stall path: HALT freezes all state until pcrst.
module main_pn #(
    parameter string IMEM_FILE = "prog.hex",
    parameter string DMEM_FILE = ""
) (
    input logic clk,
    input logic pcrst
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_JMP  = 4'h9,
        OP_BEQZ = 4'hA,
        OP_BNEZ = 4'hB,
        OP_MOV  = 4'hC,
        OP_SHL  = 4'hD,
        OP_SHR  = 4'hE,
        OP_HALT = 4'hF
    } op_t;

    logic [15:0] imem [0:255];
    logic [7:0]  dmem [0:255];
    logic [7:0]  regs [0:3];
    logic [7:0]  pc;
    logic        halted;

    logic [15:0] instr;
    op_t         op;
    logic [1:0]  rd_idx;
    logic [1:0]  rs_idx;
    logic [7:0]  imm;
    logic [7:0]  rd_val;
    logic [7:0]  rs_val;
    logic [7:0]  mem_rdata;
    logic [7:0]  wr_val;
    logic [7:0]  next_pc;
    logic        wr_en;
    logic        st_en;
    logic        halt_set;

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i] = '0;
        end
    end

    always_comb begin
        instr     = imem[pc];
        op        = op_t'(instr[15:12]);
        rd_idx    = instr[11:10];
        rs_idx    = instr[9:8];
        imm       = instr[7:0];
        rd_val    = regs[rd_idx];
        rs_val    = regs[rs_idx];
        mem_rdata = dmem[imm];

        wr_en     = 1'b0;
        wr_val    = rd_val;
        st_en     = 1'b0;
        halt_set  = 1'b0;
        next_pc   = pc + 8'd1;

        unique case (op)
            OP_NOP: begin
            end
            OP_LDI: begin
                wr_en  = 1'b1;
                wr_val = imm;
            end
            OP_ADD: begin
                wr_en  = 1'b1;
                wr_val = rd_val + rs_val;
            end
            OP_SUB: begin
                wr_en  = 1'b1;
                wr_val = rd_val - rs_val;
            end
            OP_AND: begin
                wr_en  = 1'b1;
                wr_val = rd_val & rs_val;
            end
            OP_OR: begin
                wr_en  = 1'b1;
                wr_val = rd_val | rs_val;
            end
            OP_XOR: begin
                wr_en  = 1'b1;
                wr_val = rd_val ^ rs_val;
            end
            OP_LD: begin
                wr_en  = 1'b1;
                wr_val = mem_rdata;
            end
            OP_ST: begin
                st_en = 1'b1;
            end
            OP_JMP: begin
                next_pc = imm;
            end
            OP_BEQZ: begin
                if (rd_val == 8'd0) begin
                    next_pc = imm;
                end
            end
            OP_BNEZ: begin
                if (rd_val != 8'd0) begin
                    next_pc = imm;
                end
            end
            OP_MOV: begin
                wr_en  = 1'b1;
                wr_val = rs_val;
            end
            OP_SHL: begin
                wr_en  = 1'b1;
                wr_val = {rd_val[6:0], 1'b0};
            end
            OP_SHR: begin
                wr_en  = 1'b1;
                wr_val = {1'b0, rd_val[7:1]};
            end
            OP_HALT: begin
                halt_set = 1'b1;
                next_pc  = pc;
            end
        endcase
    end

    // Reset wins over whatever the current instruction would have done.
    always_ff @(posedge clk) begin
        if (pcrst) begin
            pc     <= 8'd0;
            halted <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'd0;
            end
        end else if (!halted) begin
            pc <= next_pc;
            if (wr_en) begin
                regs[rd_idx] <= wr_val;
            end
            if (halt_set) begin
                halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!pcrst && !halted && st_en) begin
            dmem[imm] <= rd_val;
        end
    end

endmodule

// File: tb/tb_main_pn.sv
// Bench for main_pn: ALU vector table, directed multi-cycle programs, randomized programs vs ISA model.
module tb_main_pn;

    logic clk;
    logic pcrst;

    main_pn #(.IMEM_FILE(""), .DMEM_FILE("")) dut (
        .clk   (clk),
        .pcrst (pcrst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instruction-set model state, stepped once per clock edge alongside the DUT.
    logic [15:0] m_imem [256];
    logic [7:0]  m_dmem [256];
    logic [7:0]  m_regs [4];
    logic [7:0]  m_pc;
    logic        m_halted;

    logic [15:0] pg [256];

    typedef struct packed {
        logic [3:0] op;
        logic       same;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expv;
    } alu_vec_t;

    alu_vec_t vecs [12];

    function automatic logic [15:0] ins(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s,
                                        input logic [7:0] im);
        return {o, d, s, im};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic model_step(input logic rst);
        logic [15:0] w;
        logic [7:0]  a, b, im;
        int          d, s, npc;
        if (rst) begin
            m_pc     = 8'd0;
            m_halted = 1'b0;
            for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
            return;
        end
        if (m_halted) return;
        w   = m_imem[m_pc];
        d   = int'(w[11:10]);
        s   = int'(w[9:8]);
        im  = w[7:0];
        a   = m_regs[d];
        b   = m_regs[s];
        npc = (int'(m_pc) + 1) % 256;
        case (w[15:12])
            4'h1: m_regs[d] = im;
            4'h2: m_regs[d] = 8'((int'(a) + int'(b)) % 256);
            4'h3: m_regs[d] = 8'((int'(a) - int'(b) + 256) % 256);
            4'h4: m_regs[d] = a & b;
            4'h5: m_regs[d] = a | b;
            4'h6: m_regs[d] = a ^ b;
            4'h7: m_regs[d] = m_dmem[im];
            4'h8: m_dmem[im] = a;
            4'h9: npc = int'(im);
            4'hA: if (a == 0) npc = int'(im);
            4'hB: if (a != 0) npc = int'(im);
            4'hC: m_regs[d] = b;
            4'hD: m_regs[d] = 8'((int'(a) * 2) % 256);
            4'hE: m_regs[d] = 8'(int'(a) / 2);
            4'hF: begin
                m_halted = 1'b1;
                npc      = int'(m_pc);
            end
            default: ;
        endcase
        m_pc = 8'(npc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(pcrst);
        #1;
    endtask

    task automatic load(input int n);
        logic [15:0] v;
        for (int i = 0; i < 256; i++) begin
            v = (i < n) ? pg[i] : 16'h0000;
            m_imem[i]    = v;
            dut.imem[i]  = v;
        end
    endtask

    task automatic do_reset();
        pcrst = 1'b1;
        tick();
        tick();
        pcrst = 1'b0;
    endtask

    task automatic load_loop();
        pg[0] = ins(4'h1, 2'd0, 2'd0, 8'd3);
        pg[1] = ins(4'h1, 2'd1, 2'd0, 8'd1);
        pg[2] = ins(4'h3, 2'd0, 2'd1, 8'd0);
        pg[3] = ins(4'hB, 2'd0, 2'd0, 8'd2);
        pg[4] = ins(4'hF, 2'd0, 2'd0, 8'd0);
        load(5);
    endtask

    initial begin
        int bad;
        pcrst    = 1'b1;
        m_pc     = 8'd0;
        m_halted = 1'b0;
        for (int i = 0; i < 256; i++) m_dmem[i] = 8'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;

        vecs[0]  = '{op: 4'h2, same: 1'b0, a: 8'h05, b: 8'hFE, expv: 8'h03};
        vecs[1]  = '{op: 4'h2, same: 1'b0, a: 8'hFF, b: 8'h01, expv: 8'h00};
        vecs[2]  = '{op: 4'h3, same: 1'b0, a: 8'h00, b: 8'h01, expv: 8'hFF};
        vecs[3]  = '{op: 4'h4, same: 1'b0, a: 8'hF0, b: 8'h3C, expv: 8'h30};
        vecs[4]  = '{op: 4'h5, same: 1'b0, a: 8'hF0, b: 8'h0F, expv: 8'hFF};
        vecs[5]  = '{op: 4'h6, same: 1'b0, a: 8'hAA, b: 8'hFF, expv: 8'h55};
        vecs[6]  = '{op: 4'hC, same: 1'b0, a: 8'h12, b: 8'h34, expv: 8'h34};
        vecs[7]  = '{op: 4'hD, same: 1'b0, a: 8'h81, b: 8'h00, expv: 8'h02};
        vecs[8]  = '{op: 4'hE, same: 1'b0, a: 8'h81, b: 8'h00, expv: 8'h40};
        vecs[9]  = '{op: 4'h2, same: 1'b1, a: 8'h81, b: 8'h77, expv: 8'h02};
        vecs[10] = '{op: 4'h3, same: 1'b1, a: 8'h5A, b: 8'h77, expv: 8'h00};
        vecs[11] = '{op: 4'h0, same: 1'b0, a: 8'h9C, b: 8'h11, expv: 8'h9C};

        // Reset holds pc at 0; first released edge runs imem[0] (NOP).
        load(0);
        pcrst = 1'b1;
        tick();
        tick();
        tick();
        check("rst_pc", dut.pc, 8'h00);
        check("rst_halted", dut.halted, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("rst_r%0d", i), dut.regs[i], 8'h00);
        pcrst = 1'b0;
        tick();
        check("rel_pc", dut.pc, 8'h01);

        for (int v = 0; v < 12; v++) begin
            pg[0] = ins(4'h1, 2'd0, 2'd0, vecs[v].a);
            pg[1] = ins(4'h1, 2'd1, 2'd0, vecs[v].b);
            pg[2] = ins(vecs[v].op, 2'd0, vecs[v].same ? 2'd0 : 2'd1, 8'h00);
            pg[3] = ins(4'hF, 2'd0, 2'd0, 8'h00);
            load(4);
            do_reset();
            repeat (4) tick();
            check($sformatf("vec%0d_r0", v), dut.regs[0], vecs[v].expv);
            check($sformatf("vec%0d_r1", v), dut.regs[1], vecs[v].b);
            check($sformatf("vec%0d_halt", v), dut.halted, 1'b1);
        end

        // Arithmetic program, then confirm HALT freezes pc.
        pg[0] = ins(4'h1, 2'd0, 2'd0, 8'h05);
        pg[1] = ins(4'h1, 2'd1, 2'd0, 8'hFE);
        pg[2] = ins(4'h2, 2'd0, 2'd1, 8'h00);
        pg[3] = ins(4'h3, 2'd1, 2'd0, 8'h00);
        pg[4] = ins(4'hF, 2'd0, 2'd0, 8'h00);
        load(5);
        do_reset();
        repeat (5) tick();
        check("arith_r0", dut.regs[0], 8'h03);
        check("arith_r1", dut.regs[1], 8'hFB);
        check("arith_halted", dut.halted, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("arith_hold_pc%0d", i), dut.pc, 8'h04);
        end

        // Store then load same address on the very next instruction.
        pg[0] = ins(4'h1, 2'd2, 2'd0, 8'hA5);
        pg[1] = ins(4'h8, 2'd2, 2'd0, 8'h10);
        pg[2] = ins(4'h7, 2'd3, 2'd0, 8'h10);
        pg[3] = ins(4'hF, 2'd0, 2'd0, 8'h00);
        load(4);
        do_reset();
        repeat (4) tick();
        check("mem_dmem10", dut.dmem[8'h10], 8'hA5);
        check("mem_r3", dut.regs[3], 8'hA5);

        // Countdown loop retires HALT on exactly the 9th edge.
        load_loop();
        do_reset();
        repeat (8) tick();
        check("loop_not_halted_8", dut.halted, 1'b0);
        tick();
        check("loop_halted_9", dut.halted, 1'b1);
        check("loop_r0", dut.regs[0], 8'h00);
        check("loop_pc", dut.pc, 8'h04);

        // pc wraps 0xFF -> 0x00.
        pg[0] = ins(4'h9, 2'd0, 2'd0, 8'hFF);
        load(1);
        do_reset();
        tick();
        check("wrap_pc_ff", dut.pc, 8'hFF);
        tick();
        check("wrap_pc_00", dut.pc, 8'h00);

        // Reset in the middle of the loop: state cleared, RAM kept, rerun matches.
        load_loop();
        do_reset();
        repeat (5) tick();
        pcrst = 1'b1;
        tick();
        check("mid_pc", dut.pc, 8'h00);
        check("mid_r0", dut.regs[0], 8'h00);
        check("mid_r1", dut.regs[1], 8'h00);
        check("mid_dmem_kept", dut.dmem[8'h10], 8'hA5);
        pcrst = 1'b0;
        repeat (9) tick();
        check("rerun_r0", dut.regs[0], 8'h00);
        check("rerun_r1", dut.regs[1], 8'h01);
        check("rerun_halted", dut.halted, 1'b1);
        check("rerun_pc", dut.pc, 8'h04);

        // Reset on the edge that would have stored must drop the store.
        pg[0] = ins(4'h1, 2'd0, 2'd0, 8'h77);
        pg[1] = ins(4'h8, 2'd0, 2'd0, 8'h20);
        load(2);
        do_reset();
        tick();
        pcrst = 1'b1;
        tick();
        check("rst_drops_st", dut.dmem[8'h20], 8'h00);
        check("rst_drops_st_pc", dut.pc, 8'h00);
        pcrst = 1'b0;

        // Random programs over the whole ROM, with occasional resets, against the model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) pg[i] = 16'($urandom);
            load(256);
            do_reset();
            for (int c = 0; c < 60; c++) begin
                pcrst = ($urandom_range(0, 24) == 0);
                tick();
                check($sformatf("rnd%0d_pc", r), dut.pc, m_pc);
                check($sformatf("rnd%0d_halted", r), dut.halted, m_halted);
                check($sformatf("rnd%0d_regs", r), {dut.regs[3], dut.regs[2], dut.regs[1], dut.regs[0]},
                      {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            end
            pcrst = 1'b0;
            bad = 0;
            for (int i = 0; i < 256; i++) if (dut.dmem[i] !== m_dmem[i]) bad++;
            check($sformatf("rnd%0d_dmem_mismatches", r), bad, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
